// File: rtl/mem_pkg.sv
// Shared definitions for the data RAM port.
//   - Size codes for byte, half and word accesses.
//   - Clear-FSM state enum.
//   - Response pipeline stage record.
//   - Helper functions: misalignment check and write-lane mask.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_e;

  // One slot of the response pipeline. The raw word is carried and
  // aligned/extended at the output.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [1:0]  ofs;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] word;
  } resp_stage_t;

  // Flags an access as misaligned. Size code 3 is always illegal.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] ofs);
    logic bad;
    unique case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = ofs[0];
      SZ_W:    bad = (ofs != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte lanes touched by an aligned store of the given size at the
  // given byte offset within the word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] ofs);
    logic [3:0] m;
    unique case (size)
      SZ_B:    m = 4'b0001 << ofs;
      SZ_H:    m = ofs[1] ? 4'b1100 : 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load alignment and extension (purely combinational).
//   word_i  : raw 32-bit word read from the array
//   ofs_i   : byte offset within the word (addr[1:0])
//   size_i  : access size code
//   uns_i   : 1 = zero-extend, 0 = sign-extend
//   data_o  : selected byte/half moved to bit 0 and extended to 32 bits
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  ofs_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (ofs_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = ofs_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    unique case (size_i)
      SZ_B:    data_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
      SZ_H:    data_o = {{16{~uns_i & half_sel[15]}}, half_sel};
      SZ_W:    data_o = word_i;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_ram_port.sv
// Data RAM behind a valid/ready load/store port.
//   clk, rst      : clock, asynchronous active-high reset
//   req_*         : request (valid/ready, we, byte address, size,
//                   unsigned flag, store data)
//   resp_valid    : one-cycle pulse per load or error response
//   resp_rdata    : extended load data, 0 on error
//   resp_err      : misaligned or illegal-size access
//   busy          : post-reset clear sequence running (req_ready = !busy)
// Stores complete on the accept edge. Loads sample the word on the accept
// edge and respond READ_LAT-1 edges later. The array is zeroed after
// reset when INIT_CLEAR is set.
module data_ram_port
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int READ_LAT   = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam clr_state_e RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
    $error("data_ram_port: READ_LAT must be 1 or 2");
  end

  logic [31:0] mem [DEPTH];

  // Clear FSM: state register
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear FSM: next state. The edge writing the last word leaves CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_IDLE;
    end
  end

  // Clear FSM: outputs
  always_comb begin
    busy = (state_q == ST_CLEAR);
  end

  assign req_ready = ~busy;

  // Request decode
  logic              accept;
  logic [ADDR_W-1:0] waddr;
  logic [1:0]        ofs;
  logic              mis;
  logic [3:0]        lane_we;
  logic [31:0]       wdata_rep;
  logic [31:0]       rd_word;

  assign accept  = req_valid & req_ready;
  assign waddr   = req_addr[ADDR_W+1:2];
  assign ofs     = req_addr[1:0];
  assign mis     = misaligned(req_size, ofs);
  assign lane_we = (accept && req_we && !mis) ? lane_mask(req_size, ofs) : 4'b0000;
  assign rd_word = mem[waddr];

  // Replicate the low bytes of the store data across all lanes; the lane
  // mask picks which of them land.
  always_comb begin
    unique case (req_size)
      SZ_B:    wdata_rep = {4{req_wdata[7:0]}};
      SZ_H:    wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  // Array: no reset; zeroed only by the clear sequence. Requests are never
  // accepted while clearing, so the two write sources are exclusive.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q] <= 32'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we[i]) mem[waddr][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  // Stage p0: captured on the accept edge. Only loads and misaligned
  // accesses produce a response; otherwise the payload is held so the
  // outputs keep their last values.
  resp_stage_t pipe_p0_q, pipe_p0_d;
  resp_stage_t out_s;

  always_comb begin
    pipe_p0_d       = pipe_p0_q;
    pipe_p0_d.valid = 1'b0;
    if (accept && (!req_we || mis)) begin
      pipe_p0_d.valid = 1'b1;
      pipe_p0_d.err   = mis;
      pipe_p0_d.ofs   = ofs;
      pipe_p0_d.size  = req_size;
      pipe_p0_d.uns   = req_unsigned;
      pipe_p0_d.word  = rd_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_p0_q <= '0;
    else     pipe_p0_q <= pipe_p0_d;
  end

  // Stage p1: optional extra cycle of load latency
  if (READ_LAT == 2) begin : g_lat2
    resp_stage_t pipe_p1_q, pipe_p1_d;

    always_comb begin
      pipe_p1_d       = pipe_p1_q;
      pipe_p1_d.valid = 1'b0;
      if (pipe_p0_q.valid) pipe_p1_d = pipe_p0_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_p1_q <= '0;
      else     pipe_p1_q <= pipe_p1_d;
    end

    assign out_s = pipe_p1_q;
  end else begin : g_lat1
    assign out_s = pipe_p0_q;
  end

  // Output: align/extend the carried word; errors force data to zero
  logic [31:0] aligned;

  mem_load_align u_align (
    .word_i (out_s.word),
    .ofs_i  (out_s.ofs),
    .size_i (out_s.size),
    .uns_i  (out_s.uns),
    .data_o (aligned)
  );

  assign resp_valid = out_s.valid;
  assign resp_err   = out_s.err;
  assign resp_rdata = out_s.err ? 32'h0 : aligned;

endmodule
